// File: rtl/mem_request_splitter_nway_simd_if.sv
// rtl/mem_request_splitter_nway_simd_if.sv - request/chunk handshake bundle for the N-way splitter
//
// Request side : in_addr, in_size, in_valid -> splitter; in_ready <- splitter
// Chunk side   : out_addr, out_size, out_last, out_valid, chunk_idx <- splitter; out_ready -> splitter
// Status       : busy, done <- splitter
// master = address generator / downstream environment, slave = splitter
interface mem_request_splitter_nway_simd_if #(
    parameter int ADDR_WIDTH     = 64,
    parameter int REQ_SIZE_WIDTH = 16,
    parameter int CNT_WIDTH      = 8
);
    logic [ADDR_WIDTH-1:0]     in_addr;
    logic [REQ_SIZE_WIDTH-1:0] in_size;
    logic                      in_valid;
    logic                      in_ready;
    logic [ADDR_WIDTH-1:0]     out_addr;
    logic [REQ_SIZE_WIDTH-1:0] out_size;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [CNT_WIDTH-1:0]      chunk_idx;
    logic                      busy;
    logic                      done;

    modport master (
        output in_addr, in_size, in_valid, out_ready,
        input  in_ready, out_addr, out_size, out_last, out_valid, chunk_idx, busy, done
    );

    modport slave (
        input  in_addr, in_size, in_valid, out_ready,
        output in_ready, out_addr, out_size, out_last, out_valid, chunk_idx, busy, done
    );
endinterface

// File: rtl/mem_request_splitter_nway_simd.sv
// rtl/mem_request_splitter_nway_simd.sv - splits one (addr, size) request into boundary/burst-safe chunks
//
// Ports:
//   clk                 clock
//   reset               synchronous active-high reset
//   bus (slave)         request in (in_*), chunk out (out_*, chunk_idx), busy, done
//   stat_req_cnt        input handshake counter   (only with MEM_SPLITTER_STATS_EN)
//   stat_chunk_cnt      output handshake counter  (only with MEM_SPLITTER_STATS_EN)
// Optional feature macro: MEM_SPLITTER_STATS_EN
module mem_request_splitter_nway_simd #(
    parameter int ADDR_WIDTH     = 64,
    parameter int REQ_SIZE_WIDTH = 16,
    parameter int BOUNDARY_LOG2  = 12,
    parameter int MAX_BURST_LOG2 = 12,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clk,
    input  logic reset,
    mem_request_splitter_nway_simd_if.slave bus
`ifdef MEM_SPLITTER_STATS_EN
    ,
    output logic [31:0] stat_req_cnt,
    output logic [31:0] stat_chunk_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    // Wide enough for both the distance-to-boundary (up to 2^BOUNDARY_LOG2)
    // and a zero-extended request size.
    localparam int CW = (REQ_SIZE_WIDTH + 1 > BOUNDARY_LOG2 + 1) ? REQ_SIZE_WIDTH + 1 : BOUNDARY_LOG2 + 1;
    localparam logic [REQ_SIZE_WIDTH-1:0] MAX_CHUNK = REQ_SIZE_WIDTH'(1) << MAX_BURST_LOG2;

    state_t                    state, state_nxt;
    logic [ADDR_WIDTH-1:0]     cur_addr;
    logic [REQ_SIZE_WIDTH-1:0] rem;
    logic [REQ_SIZE_WIDTH-1:0] cur_size;
    logic                      cur_last;
    logic [CNT_WIDTH-1:0]      idx;

    logic                      load_first;
    logic                      load_next;
    logic [ADDR_WIDTH-1:0]     src_addr;
    logic [REQ_SIZE_WIDTH-1:0] src_rem;
    logic [CW-1:0]             to_bound;
    logic [REQ_SIZE_WIDTH-1:0] chunk_size;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        load_first    = 1'b0;
        load_next     = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.done      = 1'b0;
        bus.busy      = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) begin
                    if (bus.in_size != '0) begin
                        state_nxt  = ISSUE;
                        load_first = 1'b1;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            ISSUE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (cur_last) state_nxt = DONE;
                    else          load_next = 1'b1;
                end
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The next chunk is computed from either the incoming request or the
    // post-handshake address/remainder, so a new chunk is ready with no bubble.
    always_comb begin
        src_addr   = load_first ? bus.in_addr : cur_addr + ADDR_WIDTH'(cur_size);
        src_rem    = load_first ? bus.in_size : rem - cur_size;
        to_bound   = (CW'(1) << BOUNDARY_LOG2) - CW'(src_addr[BOUNDARY_LOG2-1:0]);
        chunk_size = src_rem;
        if (to_bound < CW'(chunk_size)) chunk_size = to_bound[REQ_SIZE_WIDTH-1:0];
        if (MAX_CHUNK < chunk_size)     chunk_size = MAX_CHUNK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr <= '0;
            rem      <= '0;
            cur_size <= '0;
            cur_last <= 1'b0;
            idx      <= '0;
        end else if (load_first || load_next) begin
            cur_addr <= src_addr;
            rem      <= src_rem;
            cur_size <= chunk_size;
            cur_last <= (chunk_size == src_rem);
            if (load_first)     idx <= '0;
            else if (idx != '1) idx <= idx + CNT_WIDTH'(1);
        end
    end

    assign bus.out_addr  = cur_addr;
    assign bus.out_size  = cur_size;
    assign bus.out_last  = cur_last;
    assign bus.chunk_idx = idx;

`ifdef MEM_SPLITTER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_req_cnt   <= '0;
            stat_chunk_cnt <= '0;
        end else begin
            if (bus.in_valid && bus.in_ready)   stat_req_cnt   <= stat_req_cnt + 32'd1;
            if (bus.out_valid && bus.out_ready) stat_chunk_cnt <= stat_chunk_cnt + 32'd1;
        end
    end
`endif

endmodule
